// File: rtl/msxbus_pkg.sv
// Shared encodings for the MSX slot bus host sequencer: FSM states and bridge control levels.
package msxbus_pkg;

  typedef enum logic [1:0] {
    SEQ_IDLE = 2'd0,
    SEQ_ADDR = 2'd1,
    SEQ_DATA = 2'd2,
    SEQ_REL  = 2'd3
  } seq_state_t;

  localparam logic       RW_READ     = 1'b0;
  localparam logic       RW_WRITE    = 1'b1;
  localparam logic       MMEIO_MEM   = 1'b0;
  localparam logic       MMEIO_IO    = 1'b1;
  localparam logic       SLT_1       = 1'b0;
  localparam logic [7:0] RDATA_FLOAT = 8'hFF;

  // Saturating 4-bit increment used by the phase counters.
  function automatic logic [3:0] sat_inc4(input logic [3:0] v);
    return (v == 4'hF) ? v : v + 4'd1;
  endfunction

endpackage

// File: rtl/msxbus_host_seq_if.sv
// Host request/response handshake plus the bridge-facing two-phase bus of the sequencer.
interface msxbus_host_seq_if;
  logic        req_valid;
  logic        req_ready;
  logic [15:0] req_addr;
  logic [7:0]  req_wdata;
  logic        req_rd;
  logic        req_io;
  logic        req_slot;
  logic        rsp_valid;
  logic [7:0]  rsp_rdata;
  logic        rsp_err;
  logic        cs;
  logic        a0;
  logic        rw;
  logic        mmeio;
  logic        sltsl;
  logic [15:0] md_out;
  logic        md_oe;
  logic [15:0] md_in;
  logic        ready;

  // slave: the sequencer; master: host logic together with the bridge.
  modport slave (
    input  req_valid, req_addr, req_wdata, req_rd, req_io, req_slot, md_in, ready,
    output req_ready, rsp_valid, rsp_rdata, rsp_err,
           cs, a0, rw, mmeio, sltsl, md_out, md_oe
  );

  modport master (
    output req_valid, req_addr, req_wdata, req_rd, req_io, req_slot, md_in, ready,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err,
           cs, a0, rw, mmeio, sltsl, md_out, md_oe
  );
endinterface

// File: rtl/msxbus_host_seq.sv
// MSX slot bus host sequencer: one request -> address phase, data phase, release; optional ready timeout (MSXBUS_SEQ_TIMEOUT_EN).
// Latency accept->rsp_valid: ADDR_CYCLES + max(DATA_CYCLES, ready wait) + 1 clocks.
// Backpressure: req_ready only in IDLE; rsp_valid is a one-clock pulse with no backpressure.
module msxbus_host_seq
  import msxbus_pkg::*;
#(
  parameter int ADDR_CYCLES = 1,
  parameter int DATA_CYCLES = 4,
  parameter int TIMEOUT     = 255
) (
  input  logic               clk,
  input  logic               reset_n,
  msxbus_host_seq_if.slave   bus
);

  seq_state_t  state;
  logic [3:0]  acnt;
  logic [3:0]  dcnt;
  logic [3:0]  dcnt_nxt;
  logic        rd_q;
  logic [7:0]  wdata_q;
  logic        data_done;
  logic        data_tmo;
  logic        data_exit;
  logic        unused_md_hi;

  // dcnt_nxt counts the DATA clock now ending, so exit happens on the DATA_CYCLES-th clock at the earliest.
  assign dcnt_nxt  = sat_inc4(dcnt);
  assign data_done = (dcnt_nxt >= 4'(DATA_CYCLES)) && bus.ready;
  assign data_exit = data_done || data_tmo;

  assign bus.req_ready = (state == SEQ_IDLE);
  assign unused_md_hi  = ^bus.md_in[15:8];

`ifdef MSXBUS_SEQ_TIMEOUT_EN
  logic [7:0] wcnt;
  logic [7:0] wcnt_nxt;
  logic       err_q;

  assign wcnt_nxt = wcnt + 8'd1;
  assign data_tmo = !data_done && (wcnt_nxt == 8'(TIMEOUT));
`else
  logic unused_timeout;

  assign data_tmo       = 1'b0;
  assign unused_timeout = ^TIMEOUT;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state         <= SEQ_IDLE;
      bus.cs        <= 1'b1;
      bus.a0        <= 1'b1;
      bus.rw        <= RW_WRITE;
      bus.mmeio     <= MMEIO_IO;
      bus.sltsl     <= SLT_1;
      bus.md_oe     <= 1'b0;
      bus.md_out    <= 16'h0000;
      bus.rsp_valid <= 1'b0;
      bus.rsp_err   <= 1'b0;
      bus.rsp_rdata <= RDATA_FLOAT;
      acnt          <= 4'd0;
      dcnt          <= 4'd0;
      rd_q          <= 1'b0;
      wdata_q       <= 8'h00;
`ifdef MSXBUS_SEQ_TIMEOUT_EN
      wcnt          <= 8'd0;
      err_q         <= 1'b0;
`endif
    end else begin
      bus.rsp_valid <= 1'b0;
      bus.rsp_err   <= 1'b0;
      case (state)
        SEQ_IDLE: begin
          if (bus.req_valid) begin
            state      <= SEQ_ADDR;
            bus.cs     <= 1'b0;
            bus.a0     <= 1'b0;
            bus.md_oe  <= 1'b1;
            bus.md_out <= bus.req_addr;
            bus.rw     <= ~bus.req_rd;
            bus.mmeio  <= bus.req_io;
            bus.sltsl  <= bus.req_slot;
            rd_q       <= bus.req_rd;
            wdata_q    <= bus.req_wdata;
            acnt       <= 4'd0;
          end
        end
        SEQ_ADDR: begin
          // ready is deliberately not looked at here.
          if (acnt == 4'(ADDR_CYCLES - 1)) begin
            state      <= SEQ_DATA;
            bus.a0     <= 1'b1;
            bus.md_oe  <= ~rd_q;
            bus.md_out <= rd_q ? 16'h0000 : {8'h00, wdata_q};
            dcnt       <= 4'd0;
`ifdef MSXBUS_SEQ_TIMEOUT_EN
            wcnt       <= 8'd0;
            err_q      <= 1'b0;
`endif
          end else begin
            acnt <= acnt + 4'd1;
          end
        end
        SEQ_DATA: begin
          dcnt <= dcnt_nxt;
`ifdef MSXBUS_SEQ_TIMEOUT_EN
          wcnt <= wcnt_nxt;
`endif
          if (data_exit) begin
            state      <= SEQ_REL;
            bus.cs     <= 1'b1;
            bus.a0     <= 1'b1;
            bus.md_oe  <= 1'b0;
            bus.md_out <= 16'h0000;
            bus.rw     <= RW_WRITE;
            bus.mmeio  <= MMEIO_IO;
            bus.sltsl  <= SLT_1;
            if (data_tmo) begin
              bus.rsp_rdata <= RDATA_FLOAT;
`ifdef MSXBUS_SEQ_TIMEOUT_EN
              err_q         <= 1'b1;
`endif
            end else if (rd_q) begin
              bus.rsp_rdata <= bus.md_in[7:0];
            end
          end
        end
        SEQ_REL: begin
          state         <= SEQ_IDLE;
          bus.rsp_valid <= 1'b1;
`ifdef MSXBUS_SEQ_TIMEOUT_EN
          bus.rsp_err   <= err_q;
`endif
        end
        default: state <= SEQ_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_msxbus_host_seq.sv
// Randomized scoreboard bench for msxbus_host_seq with a behavioural bridge model driving ready/md_in.
module tb_msxbus_host_seq;
  import msxbus_pkg::*;

  localparam int A  = 1;
  localparam int D  = 4;
  localparam int TO = 10;

  logic clk     = 1'b0;
  logic reset_n = 1'b0;
  int   cyc     = 0;
  int   total   = 0;
  int   bad     = 0;

  msxbus_host_seq_if bus();

  msxbus_host_seq #(.ADDR_CYCLES(A), .DATA_CYCLES(D), .TIMEOUT(TO)) dut (
    .clk    (clk),
    .reset_n(reset_n),
    .bus    (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [15:0] addr;
    logic [7:0]  wdata;
    logic        rd;
    logic        io;
    logic        slot;
    int          w;
    logic [7:0]  rbyte;
    logic [7:0]  exp_rdata;
    logic        exp_err;
    int          lat;
    int          acc;
  } txn_t;

  txn_t       exp_q[$];
  int         cur_w    = 0;
  logic       cur_rd   = 1'b0;
  logic [7:0] cur_byte = 8'h00;
  logic [7:0] model_rdata = 8'hFF;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Reference: data phase lasts max(DATA_CYCLES, ready wait) clocks, cut short by the timeout if enabled.
  task automatic issue(input txn_t t_in, input bit keep_valid);
    txn_t t;
    int   eff;
    bit   tmo;
    t = t_in;
    bus.req_valid = 1'b1;
    bus.req_addr  = t.addr;
    bus.req_wdata = t.wdata;
    bus.req_rd    = t.rd;
    bus.req_io    = t.io;
    bus.req_slot  = t.slot;
    for (int i = 0; i < 200 && !bus.req_ready; i++) @(negedge clk);
    check("req_ready_wait", {31'd0, bus.req_ready}, 32'd1);
    eff = (t.w > D) ? t.w : D;
    tmo = 1'b0;
`ifdef MSXBUS_SEQ_TIMEOUT_EN
    if (eff > TO) tmo = 1'b1;
`endif
    if (tmo) model_rdata = 8'hFF;
    else if (t.rd) model_rdata = t.rbyte;
    t.exp_rdata = model_rdata;
    t.exp_err   = tmo;
    t.lat       = tmo ? (A + TO + 1) : (A + eff + 1);
    t.acc       = cyc + 1;
    cur_w    = t.w;
    cur_rd   = t.rd;
    cur_byte = t.rbyte;
    exp_q.push_back(t);
    @(negedge clk);
    if (!keep_valid) bus.req_valid = 1'b0;
  endtask

  task automatic rand_txn(output txn_t t, input int wmax);
    t.addr  = 16'($urandom);
    t.wdata = 8'($urandom);
    t.rd    = 1'($urandom);
    t.io    = 1'($urandom);
    t.slot  = 1'($urandom);
    t.w     = $urandom_range(0, wmax);
    t.rbyte = 8'($urandom);
    t.exp_rdata = 8'h00;
    t.exp_err   = 1'b0;
    t.lat = 0;
    t.acc = 0;
  endtask

  task automatic drain();
    for (int i = 0; i < 300 && exp_q.size() != 0; i++) @(negedge clk);
    check("drain", exp_q.size(), 0);
  endtask

  // Bridge model: ready rises after w data-phase clocks; junk ready during address phase must be ignored.
  initial begin
    int dclk;
    dclk = 0;
    bus.ready = 1'b0;
    bus.md_in = 16'h0000;
    forever begin
      @(negedge clk);
      if (!bus.cs && bus.a0) begin
        dclk++;
        bus.ready = (dclk >= cur_w);
        bus.md_in = cur_rd ? {8'($urandom), cur_byte} : 16'($urandom);
      end else begin
        dclk = 0;
        bus.ready = !bus.cs ? 1'($urandom) : 1'b0;
        bus.md_in = 16'($urandom);
      end
    end
  end

  // Monitor: pops the scoreboard on every response and checks both bus phases against the queue head.
  initial begin
    logic pcs, pa0;
    txn_t t;
    pcs = 1'b1;
    pa0 = 1'b1;
    forever begin
      @(negedge clk);
      if (reset_n) begin
        if (bus.rsp_valid) begin
          if (exp_q.size() == 0) begin
            check("unexpected_rsp", {31'd0, bus.rsp_valid}, 32'd0);
          end else begin
            t = exp_q.pop_front();
            check("rsp_latency", cyc - t.acc, t.lat);
            check("rsp_rdata", {24'd0, bus.rsp_rdata}, {24'd0, t.exp_rdata});
            check("rsp_err", {31'd0, bus.rsp_err}, {31'd0, t.exp_err});
          end
        end else if (exp_q.size() != 0 && (cyc - exp_q[0].acc) > exp_q[0].lat + 4) begin
          check("rsp_timeout", cyc - exp_q[0].acc, exp_q[0].lat);
          void'(exp_q.pop_front());
        end
        if (!bus.cs && !bus.a0 && pcs && exp_q.size() != 0) begin
          check("addr_md_out", {16'd0, bus.md_out}, {16'd0, exp_q[0].addr});
          check("addr_md_oe", {31'd0, bus.md_oe}, 32'd1);
          check("addr_rw", {31'd0, bus.rw}, {31'd0, ~exp_q[0].rd});
          check("addr_mmeio", {31'd0, bus.mmeio}, {31'd0, exp_q[0].io});
          check("addr_sltsl", {31'd0, bus.sltsl}, {31'd0, exp_q[0].slot});
          check("addr_req_ready", {31'd0, bus.req_ready}, 32'd0);
        end
        if (!bus.cs && bus.a0 && !pa0 && exp_q.size() != 0) begin
          check("data_md_oe", {31'd0, bus.md_oe}, {31'd0, ~exp_q[0].rd});
          if (!exp_q[0].rd)
            check("data_md_out", {16'd0, bus.md_out}, {24'd0, exp_q[0].wdata});
          check("data_rw", {31'd0, bus.rw}, {31'd0, ~exp_q[0].rd});
          check("data_mmeio", {31'd0, bus.mmeio}, {31'd0, exp_q[0].io});
          check("data_sltsl", {31'd0, bus.sltsl}, {31'd0, exp_q[0].slot});
        end
      end
      pcs = bus.cs;
      pa0 = bus.a0;
    end
  end

  initial begin
    txn_t t;
    bus.req_valid = 1'b0;
    bus.req_addr  = 16'h0000;
    bus.req_wdata = 8'h00;
    bus.req_rd    = 1'b0;
    bus.req_io    = 1'b0;
    bus.req_slot  = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_cs", {31'd0, bus.cs}, 32'd1);
    check("rst_a0", {31'd0, bus.a0}, 32'd1);
    check("rst_rw", {31'd0, bus.rw}, 32'd1);
    check("rst_mmeio", {31'd0, bus.mmeio}, 32'd1);
    check("rst_sltsl", {31'd0, bus.sltsl}, 32'd0);
    check("rst_md_oe", {31'd0, bus.md_oe}, 32'd0);
    check("rst_md_out", {16'd0, bus.md_out}, 32'd0);
    check("rst_rsp_valid", {31'd0, bus.rsp_valid}, 32'd0);
    check("rst_rsp_err", {31'd0, bus.rsp_err}, 32'd0);
    check("rst_rsp_rdata", {24'd0, bus.rsp_rdata}, 32'hFF);
    check("rst_req_ready", {31'd0, bus.req_ready}, 32'd1);
    reset_n = 1'b1;
    repeat (2) @(negedge clk);

    // Memory read, slot 1, ready after 2 clocks.
    rand_txn(t, 0);
    t.addr = 16'h4010; t.rd = 1'b1; t.io = 1'b0; t.slot = 1'b0; t.w = 2; t.rbyte = 8'hA5;
    issue(t, 1'b0);
    drain();
    check("t1_rdata_hold", {24'd0, bus.rsp_rdata}, 32'hA5);

    // IO write.
    rand_txn(t, 0);
    t.addr = 16'h0098; t.wdata = 8'h3C; t.rd = 1'b0; t.io = 1'b1; t.w = 1;
    issue(t, 1'b0);
    drain();

    // ready held low for 20 data clocks.
    rand_txn(t, 0);
    t.rd = 1'b1; t.w = 20;
    issue(t, 1'b0);
    drain();

    // Three back-to-back requests with req_valid held high.
    for (int k = 0; k < 3; k++) begin
      rand_txn(t, 6);
      issue(t, k != 2);
    end
    drain();

    // Reset during the data phase.
    rand_txn(t, 0);
    t.rd = 1'b1; t.w = 20;
    issue(t, 1'b0);
    repeat (2) @(negedge clk);
    check("pre_rst_in_data", {31'd0, (!bus.cs && bus.a0)}, 32'd1);
    reset_n = 1'b0;
    #1;
    check("mid_rst_cs", {31'd0, bus.cs}, 32'd1);
    check("mid_rst_a0", {31'd0, bus.a0}, 32'd1);
    check("mid_rst_md_oe", {31'd0, bus.md_oe}, 32'd0);
    check("mid_rst_rsp_valid", {31'd0, bus.rsp_valid}, 32'd0);
    exp_q.delete();
    model_rdata = 8'hFF;
    @(negedge clk);
    reset_n = 1'b1;
    repeat (4) @(negedge clk);
    check("post_rst_rdata", {24'd0, bus.rsp_rdata}, 32'hFF);
    rand_txn(t, 3);
    t.rd = 1'b1;
    issue(t, 1'b0);
    drain();

    // Random traffic with random idle gaps.
    for (int n = 0; n < 40; n++) begin
      rand_txn(t, 13);
      issue(t, 1'b0);
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end
    drain();

    repeat (5) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
